memory_buffer_ctrl: RTL

- Command-driven sequencer for the banked PE memory buffer.
- Takes one command at a time from the layer controller: LOAD, DUMP, STREAM or STORE.
- Generates mode, one-hot bank strobes, broadcast strobes and incrementing addresses toward the buffer.
- Generates valid/ready handshakes toward the host DMA and the PE array. Data buses bypass this block.

---
 rtl/memory_buffer_ctrl_pkg.sv | 43 ++++
 rtl/memory_buffer_ctrl_rd_valid_pipe.sv | 38 +++
 rtl/memory_buffer_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/memory_buffer_ctrl_pkg.sv
// Shared definitions for the PE memory buffer sequencer.
// - Command op encodings (match the cmd_op field from the layer controller).
// - Sequencer FSM state encodings.
// - Default geometry, aligned with the buffer's bank count and depth.
// - Helpers mapping an op to its working state and to its buffer mode.
package memory_buffer_ctrl_pkg;

  localparam int N_PE_DEF     = 8;
  localparam int ADDR_RAM_DEF = 10;
  localparam int RD_LAT_DEF   = 1;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_DUMP   = 2'd1,
    OP_STREAM = 2'd2,
    OP_STORE  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DUMP   = 3'd2,
    ST_STREAM = 3'd3,
    ST_STORE  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  function automatic state_e op_state(input op_e op);
    case (op)
      OP_LOAD:   return ST_LOAD;
      OP_DUMP:   return ST_DUMP;
      OP_STREAM: return ST_STREAM;
      default:   return ST_STORE;
    endcase
  endfunction

  // STREAM and STORE talk to the PE array; the buffer must be in PE mode.
  function automatic logic is_pe_op(input op_e op);
    return (op == OP_STREAM) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memory_buffer_ctrl_rd_valid_pipe.sv
// Read-issue tracker: an RD_LAT-deep shift register of issue flags.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   issue     - a bank read is issued this cycle
//   vld_out   - the read issued RD_LAT cycles ago returns data now
//   empty     - no read is in flight
module memory_buffer_ctrl_rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic vld_out,
  output logic empty
);

  logic [RD_LAT-1:0] vld_d, vld_q;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign vld_out = vld_q[RD_LAT-1];
  assign empty   = (vld_q == '0);

endmodule

// File: rtl/memory_buffer_ctrl.sv
// Command-driven sequencer for the banked PE memory buffer.
// Accepts one LOAD / DUMP / STREAM / STORE command at a time and drives the
// buffer's mode, bank strobes and addresses plus the host/PE handshakes.
// Data buses bypass this block.
// Ports:
//   cmd_*           - command handshake and fields from the layer controller
//   h_wr_valid/ready, h_rd_valid - host DMA handshakes
//   pe_in_ready, pe_out_valid, pe_res_valid - PE array handshakes
//   mode, m0_*, m1_* - buffer control (m0 = per-bank host side, m1 = broadcast)
//   busy, done, err - status (done/err are one-cycle pulses)
module memory_buffer_ctrl
  import memory_buffer_ctrl_pkg::*;
#(
  parameter int N_PE     = N_PE_DEF,
  parameter int ADDR_RAM = ADDR_RAM_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(N_PE)-1:0]    cmd_bank,
  input  logic [ADDR_RAM-1:0]        cmd_addr,
  input  logic [ADDR_RAM:0]          cmd_len,
  input  logic                       h_wr_valid,
  output logic                       h_wr_ready,
  output logic                       h_rd_valid,
  input  logic                       pe_in_ready,
  output logic                       pe_out_valid,
  input  logic                       pe_res_valid,
  output logic                       mode,
  output logic [N_PE-1:0]            m0_w_en,
  output logic [N_PE-1:0]            m0_r_en,
  output logic [ADDR_RAM-1:0]        m0_w_addr,
  output logic [ADDR_RAM-1:0]        m0_r_addr,
  output logic                       m1_w_en,
  output logic                       m1_r_en,
  output logic [ADDR_RAM-1:0]        m1_w_addr,
  output logic [ADDR_RAM-1:0]        m1_r_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int BANK_W = $clog2(N_PE);
  localparam logic [ADDR_RAM+1:0] ADDR_SPAN = (ADDR_RAM+2)'(1) << ADDR_RAM;

  state_e               state_d, state_q;
  op_e                  op_d, op_q;
  logic [BANK_W-1:0]    bank_d, bank_q;
  logic [ADDR_RAM-1:0]  ptr_d, ptr_q;
  logic [ADDR_RAM:0]    rem_d, rem_q;
  logic                 mode_d, mode_q;
  logic                 err_d, err_q;

  logic [N_PE-1:0]      bank_oh;
  logic [ADDR_RAM+1:0]  end_addr;
  logic                 cmd_bad;
  logic                 beat;
  logic                 issue;
  logic                 rd_vld;
  logic                 rd_empty;

  assign bank_oh  = N_PE'(1) << bank_q;
  // One bit wider than the span so the full-range end address is representable.
  assign end_addr = (ADDR_RAM+2)'(cmd_addr) + (ADDR_RAM+2)'(cmd_len);
  assign cmd_bad  = (cmd_len == '0) || (end_addr > ADDR_SPAN);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    bank_d     = bank_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    err_d      = 1'b0;
    h_wr_ready = 1'b0;
    m0_w_en    = '0;
    m0_r_en    = '0;
    m1_w_en    = 1'b0;
    m1_r_en    = 1'b0;
    beat       = 1'b0;
    issue      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          bank_d = cmd_bank;
          ptr_d  = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = op_state(op_e'(cmd_op));
            mode_d  = is_pe_op(op_e'(cmd_op));
          end
        end
      end
      ST_LOAD: begin
        h_wr_ready = 1'b1;
        if (h_wr_valid) begin
          m0_w_en = bank_oh;
          beat    = 1'b1;
        end
      end
      ST_STORE: begin
        if (pe_res_valid) begin
          m1_w_en = 1'b1;
          beat    = 1'b1;
        end
      end
      ST_DUMP: begin
        m0_r_en = bank_oh;
        issue   = 1'b1;
      end
      ST_STREAM: begin
        if (pe_in_ready) begin
          m1_r_en = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_DRAIN: begin
        // The buffer's host read mux selects on m0_r_en, so keep it up
        // until the last in-flight DUMP word has been delivered.
        if (op_q == OP_DUMP) begin
          m0_r_en = bank_oh;
        end
        if (rd_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mode_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Shared beat/issue bookkeeping. On the final beat ptr holds, so it
    // never steps past the last valid address and cannot roll over.
    if (beat || issue) begin
      rem_d = rem_q - (ADDR_RAM+1)'(1);
      if (rem_q == (ADDR_RAM+1)'(1)) begin
        state_d = beat ? ST_DONE : ST_DRAIN;
      end else begin
        ptr_d = ptr_q + ADDR_RAM'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      bank_q  <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bank_q  <= bank_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  memory_buffer_ctrl_rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .issue   (issue),
    .vld_out (rd_vld),
    .empty   (rd_empty)
  );

  assign h_rd_valid   = rd_vld && (op_q == OP_DUMP);
  assign pe_out_valid = rd_vld && (op_q == OP_STREAM);

  assign m0_w_addr = ptr_q;
  assign m0_r_addr = ptr_q;
  assign m1_w_addr = ptr_q;
  assign m1_r_addr = ptr_q;

  assign mode      = mode_q;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule
